// File: rtl/mul_sched_pkg.sv
// mul_sched_pkg: shared widths and the tag carried alongside each multiplier operation.
// Ports: none (package).
package mul_sched_pkg;
    localparam int DATA_W = 32;
    localparam int PROD_W = 2 * DATA_W;
    localparam int ID_W   = 3;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant among N_REQ requesters.
// Ports: clk, reset (sync, active-high); req in; accept in (advance pointer);
//        grant out (one-hot or zero); gid out (index of the granted requester).
module rr_arbiter import mul_sched_pkg::*; #(
    parameter int N_REQ = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             accept,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  gid
);
    logic [ID_W-1:0] ptr;
    int j;

    // Scan from the farthest offset back to the pointer so the nearest requester wins.
    always_comb begin
        grant = '0;
        gid = '0;
        j = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N_REQ;
            if (!reset && |((req >> j) & N_REQ'(1))) begin
                grant = N_REQ'(1) << j;
                gid = ID_W'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            ptr <= '0;
        else if (accept)
            ptr <= (int'(gid) + 1 == N_REQ) ? '0 : gid + 1'b1;
    end
endmodule

// File: rtl/mul_scheduler.sv
// mul_scheduler: shares one pipelined multiplier among N_REQ requesters with tagged returns.
// Ports: clk, reset (sync, active-high); req_valid/req_ready/req_a/req_b request side;
//        resp_valid/resp_r response side; mul_a/mul_b/mul_r multiplier side; issue_count.
module mul_scheduler #(
    parameter int N_REQ       = 4,
    parameter int MUL_LATENCY = 2,
    parameter int DATA_W      = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*DATA_W-1:0] req_a,
    input  logic [N_REQ*DATA_W-1:0] req_b,
    output logic [N_REQ-1:0]        resp_valid,
    output logic [2*DATA_W-1:0]     resp_r,
    output logic [DATA_W-1:0]       mul_a,
    output logic [DATA_W-1:0]       mul_b,
    input  logic [2*DATA_W-1:0]     mul_r,
    output logic [31:0]             issue_count
);
    import mul_sched_pkg::*;

    logic [ID_W-1:0] gid;
    logic hs;
    // tags[MUL_LATENCY] lines up with the product arriving on mul_r.
    tag_t [MUL_LATENCY:0] tags;

    assign hs = |(req_valid & req_ready);

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk(clk),
        .reset(reset),
        .req(req_valid),
        .accept(hs),
        .grant(req_ready),
        .gid(gid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            mul_a <= '0;
            mul_b <= '0;
            tags <= '0;
            resp_valid <= '0;
            resp_r <= '0;
            issue_count <= '0;
        end else begin
            if (hs) begin
                mul_a <= DATA_W'(req_a >> (int'(gid) * DATA_W));
                mul_b <= DATA_W'(req_b >> (int'(gid) * DATA_W));
                issue_count <= issue_count + 32'd1;
            end
            tags <= {tags[MUL_LATENCY-1:0], tag_t'{valid: hs, id: gid}};
            resp_valid <= tags[MUL_LATENCY].valid ? N_REQ'(1) << tags[MUL_LATENCY].id : '0;
            if (tags[MUL_LATENCY].valid)
                resp_r <= mul_r;
        end
    end
endmodule

// File: tb/tb_mul_scheduler.sv
// tb_mul_scheduler: randomized self-checking bench for mul_scheduler against a queue-based model.
module tb_mul_scheduler;
    localparam int N = 4;
    localparam int DW = 32;

    typedef struct {
        int          id;
        logic [63:0] prod;
        int          due;
    } ent_t;

    logic clk = 0;
    logic reset = 1;
    logic [N-1:0] req_valid = '0;
    logic [N-1:0] req_ready, resp_valid;
    logic [N*DW-1:0] req_a = '0, req_b = '0;
    logic [63:0] resp_r, mul_r, p1;
    logic [31:0] mul_a, mul_b, issue_count;

    int errors = 0, checks = 0, cyc = 0;
    ent_t q[$];
    int order[$];
    int ptr = 0, seen[N], first2 = 0, last2 = 0;
    logic [31:0] ecnt = 0, ea = 0, eb = 0;
    logic [63:0] lr = 0, first_r2 = 0;
    logic [N-1:0] hs_vec = '0;
    logic [N-1:0] en = '0;
    int en_pct = 100, left = 0;
    bit stream = 0;
    logic [31:0] sa = 0, sb = 0;

    always #5 clk = ~clk;

    mul_scheduler #(.N_REQ(N), .MUL_LATENCY(2), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_r(resp_r),
        .mul_a(mul_a), .mul_b(mul_b), .mul_r(mul_r), .issue_count(issue_count)
    );

    // Two-stage multiplier: product appears on mul_r two edges after mul_a/mul_b settle.
    always @(posedge clk) begin
        p1 <= {32'b0, mul_a} * {32'b0, mul_b};
        mul_r <= p1;
    end

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rnd();
        case ($urandom_range(3))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    // Reference model: every accepted pair becomes a queued product due 3 edges after acceptance.
    always @(negedge clk) begin
        if (cyc > 0) begin
            if (q.size() > 0 && q[0].due == cyc) begin
                ent_t e;
                e = q.pop_front();
                chk("resp_valid", 64'(resp_valid), 64'(1) << e.id);
                chk("resp_r", resp_r, e.prod);
                lr = e.prod;
                seen[e.id]++;
                if (e.id == 2) begin
                    if (seen[2] == 1) begin
                        first2 = cyc;
                        first_r2 = resp_r;
                    end
                    last2 = cyc;
                end
            end else begin
                chk("resp_idle", 64'(resp_valid), 0);
                chk("resp_hold", resp_r, lr);
            end
            chk("mul_a", 64'(mul_a), 64'(ea));
            chk("mul_b", 64'(mul_b), 64'(eb));
            chk("issue_count", 64'(issue_count), 64'(ecnt));
            if (reset) begin
                chk("ready_in_reset", 64'(req_ready), 0);
                q.delete();
                order.delete();
                ptr = 0; ecnt = 0; ea = 0; eb = 0; lr = 0; hs_vec = '0;
                for (int i = 0; i < N; i++) seen[i] = 0;
                first2 = 0; last2 = 0;
            end else begin
                int g;
                g = -1;
                for (int k = 0; k < N; k++)
                    if (g < 0 && req_valid[(ptr + k) % N]) g = (ptr + k) % N;
                chk("grant", 64'(req_ready), g < 0 ? 64'(0) : 64'(1) << g);
                hs_vec = req_valid & req_ready;
                if (g >= 0) begin
                    logic [31:0] a, b;
                    a = req_a[g*DW +: DW];
                    b = req_b[g*DW +: DW];
                    q.push_back('{id: g, prod: {32'b0, a} * {32'b0, b}, due: cyc + 4});
                    ptr = (g + 1) % N;
                    ea = a; eb = b;
                    ecnt++;
                    order.push_back(g);
                end
            end
        end
    end

    // Requesters hold until granted, then optionally raise a fresh request.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs_vec[i] || !req_valid[i]) begin
                if (en[i] && $urandom_range(99) < en_pct && !(stream && left == 0)) begin
                    req_valid[i] = 1'b1;
                    if (stream) begin
                        req_a[i*DW +: DW] = sa;
                        req_b[i*DW +: DW] = sb;
                        sa += 32'h23456789;
                        sb += 32'h34567891;
                        left--;
                    end else begin
                        req_a[i*DW +: DW] = rnd();
                        req_b[i*DW +: DW] = rnd();
                    end
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    end

    task automatic do_reset();
        en = '0;
        stream = 0;
        req_valid = '0;
        reset = 1;
        repeat (2) @(posedge clk);
        #2 reset = 0;
    endtask

    initial begin
        int reps, tot;
        do_reset();

        req_a[1*DW +: DW] = 32'd3;
        req_b[1*DW +: DW] = 32'd5;
        req_valid = 4'b0010;
        repeat (8) @(posedge clk);
        #2;
        chk("t1_seen", 64'(seen[1]), 1);
        chk("t1_r", resp_r, 64'd15);
        chk("t1_cnt", 64'(issue_count), 1);

        do_reset();
        for (int i = 0; i < N; i++) begin
            req_a[i*DW +: DW] = rnd();
            req_b[i*DW +: DW] = rnd();
        end
        req_valid = '1;
        repeat (10) @(posedge clk);
        #2;
        chk("t2_n", 64'(order.size()), 4);
        for (int k = 0; k < 4 && k < order.size(); k++)
            chk($sformatf("t2_order%0d", k), 64'(order[k]), 64'(k));
        chk("t2_cnt", 64'(issue_count), 4);
        tot = 0;
        for (int i = 0; i < N; i++) tot += seen[i];
        chk("t2_resp", 64'(tot), 4);

        do_reset();
        en = 4'b1001; en_pct = 100;
        repeat (20) @(posedge clk);
        en = '0;
        repeat (6) @(posedge clk);
        #2;
        reps = 0;
        for (int k = 1; k < order.size(); k++)
            if (order[k] == order[k-1]) reps++;
        chk("t4_repeats", 64'(reps), 0);
        chk("t4_enough", 64'(order.size() >= 16), 1);

        do_reset();
        sa = 32'hFFFFFFFF; sb = 32'hFFFFFFFF;
        stream = 1; left = 100; en = 4'b0100; en_pct = 100;
        repeat (112) @(posedge clk);
        stream = 0; en = '0;
        #2;
        chk("t3_n", 64'(seen[2]), 100);
        chk("t3_run", 64'(last2 - first2 + 1), 100);
        chk("t3_cnt", 64'(issue_count), 100);
        chk("t3_max", first_r2, 64'hFFFFFFFE00000001);

        do_reset();
        en = '1; en_pct = 60;
        repeat (300) @(posedge clk);
        en = '0;
        repeat (10) @(posedge clk);
        #2;
        chk("rnd_drain", 64'(q.size()), 0);

        do_reset();
        en = '1; en_pct = 100;
        for (int t = 0; t < 50 && ecnt < 3; t++) @(posedge clk);
        chk("t5_accepted", 64'(ecnt >= 3), 1);
        #2;
        en = '0;
        reset = 1;
        @(posedge clk);
        #2 reset = 0;
        @(negedge clk);
        chk("t5_mul_a", 64'(mul_a), 0);
        chk("t5_mul_b", 64'(mul_b), 0);
        chk("t5_cnt", 64'(issue_count), 0);
        chk("t5_rv", 64'(resp_valid), 0);
        chk("t5_r", resp_r, 0);
        repeat (10) @(posedge clk);
        #2;
        tot = 0;
        for (int i = 0; i < N; i++) tot += seen[i];
        chk("t5_resp", 64'(tot), 64'(ecnt));

        repeat (20) @(posedge clk);
        #2;
        chk("t6_rdy", 64'(req_ready), 0);
        chk("t6_cnt", 64'(issue_count), 64'(ecnt));
        chk("t6_a", 64'(mul_a), 64'(ea));
        chk("t6_b", 64'(mul_b), 64'(eb));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
